// File: rtl/kronos_pkg.sv
// Shared constants for the Kronos compare path.
//   cmp_code_e : 2-bit compare code (EQ / op1<op2 / op1>op2).
//   F3_*       : RISC-V funct3 encodings understood by the compare sequencer.
//   f3_is_signed / f3_result : helpers mapping funct3 to signedness and to
//                              the final taken/SLT bit.
package kronos_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10
  } cmp_code_e;

  localparam logic [2:0] F3_EQ   = 3'b000;
  localparam logic [2:0] F3_NE   = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_LT   = 3'b100;
  localparam logic [2:0] F3_GE   = 3'b101;
  localparam logic [2:0] F3_LTU  = 3'b110;
  localparam logic [2:0] F3_GEU  = 3'b111;

  function automatic logic f3_is_signed(input logic [2:0] f3);
    return (f3 == F3_SLT) || (f3 == F3_LT) || (f3 == F3_GE);
  endfunction

  function automatic logic f3_result(input logic [2:0] f3, input logic [1:0] code);
    logic r;
    case (f3)
      F3_EQ:                        r = (code == CMP_EQ);
      F3_NE:                        r = (code != CMP_EQ);
      F3_GE, F3_GEU:                r = (code != CMP_LT);
      default:                      r = (code == CMP_LT); // SLT/SLTU/LT/LTU
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kronos_cmp8.sv
// Combinational byte comparator.
//   a, b : byte operands
//   sgn  : treat both bytes as two's complement
//   c    : compare code (00 eq, 01 a<b, 10 a>b)
module kronos_cmp8
  import kronos_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sgn,
  output logic [1:0] c
);

  // Extend to 9 bits so one signed compare covers both modes.
  logic signed [8:0] a_x;
  logic signed [8:0] b_x;

  always_comb begin
    a_x = {sgn & a[7], a};
    b_x = {sgn & b[7], b};
    if (a == b)
      c = CMP_EQ;
    else if (a_x < b_x)
      c = CMP_LT;
    else
      c = CMP_GT;
  end

endmodule

// File: rtl/kronos_cmp_seq.sv
// Multi-cycle 32-bit compare sequencer. Walks the operand byte lanes MSB
// first through one byte comparator and reports the first differing lane.
//   EARLY_EXIT : 1 = stop at first non-equal lane, 0 = always scan 4 lanes
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid/in_ready, op1, op2, funct3 : request handshake and operands
//   out_valid/out_ready, cmp, result    : response handshake, compare code
//                                         and taken/SLT bit
module kronos_cmp_seq
  import kronos_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [2:0]  funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  cmp,
  output logic        result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] op1_q, op2_q;
  logic [2:0]  f3_q;
  logic        sgn_q;

  logic        accept;
  logic [7:0]  lane_a, lane_b;
  logic        lane_sgn;
  logic [1:0]  lane_c;

  // Lane mux: only the top byte carries the sign.
  always_comb begin
    lane_a   = op1_q[{lane_q, 3'b000} +: 8];
    lane_b   = op2_q[{lane_q, 3'b000} +: 8];
    lane_sgn = sgn_q & (lane_q == 2'd3);
  end

  kronos_cmp8 u_cmp8 (
    .a   (lane_a),
    .b   (lane_b),
    .sgn (lane_sgn),
    .c   (lane_c)
  );

  assign accept = (state_q == S_IDLE) & in_valid;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    code_d    = code_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cmp       = CMP_EQ;
    result    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_CMP;
          lane_d  = 2'd3;
          code_d  = CMP_EQ;
        end
      end
      S_CMP: begin
        // The first non-equal lane decides; later lanes cannot override it.
        if (code_q == CMP_EQ)
          code_d = lane_c;
        if (((EARLY_EXIT != 0) && (lane_c != CMP_EQ)) || (lane_q == 2'd0))
          state_d = S_DONE;
        else
          lane_d = lane_q - 2'd1;
      end
      S_DONE: begin
        out_valid = 1'b1;
        cmp       = code_q;
        result    = f3_result(f3_q, code_q);
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd3;
      code_q  <= CMP_EQ;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      code_q  <= code_d;
    end
  end

  // Operand capture is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_q <= op1;
      op2_q <= op2;
      f3_q  <= funct3;
      sgn_q <= f3_is_signed(funct3);
    end
  end

endmodule

// File: tb/tb_kronos_cmp_seq.sv
module tb_kronos_cmp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_e1, in_valid_e0;
  logic [31:0] op1, op2;
  logic [2:0]  funct3;
  logic        out_ready;

  logic        in_ready_e1, out_valid_e1, result_e1;
  logic [1:0]  cmp_e1;
  logic        in_ready_e0, out_valid_e0, result_e0;
  logic [1:0]  cmp_e0;

  logic        sel;   // 1: early-exit instance, 0: fixed-latency instance
  logic        in_ready_s, out_valid_s, result_s;
  logic [1:0]  cmp_s;

  always #5 clk = ~clk;

  kronos_cmp_seq #(.EARLY_EXIT(1)) dut_e1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_e1), .in_ready(in_ready_e1),
    .op1(op1), .op2(op2), .funct3(funct3), .out_valid(out_valid_e1),
    .out_ready(out_ready), .cmp(cmp_e1), .result(result_e1)
  );

  kronos_cmp_seq #(.EARLY_EXIT(0)) dut_e0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_e0), .in_ready(in_ready_e0),
    .op1(op1), .op2(op2), .funct3(funct3), .out_valid(out_valid_e0),
    .out_ready(out_ready), .cmp(cmp_e0), .result(result_e0)
  );

  assign in_ready_s  = sel ? in_ready_e1  : in_ready_e0;
  assign out_valid_s = sel ? out_valid_e1 : out_valid_e0;
  assign cmp_s       = sel ? cmp_e1       : cmp_e0;
  assign result_s    = sel ? result_e1    : result_e0;

  typedef struct {
    logic [1:0] cmp;
    logic       res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: full-width compare, independent of the lane walk.
  function automatic logic [1:0] model_cmp(input logic [31:0] a, b, input logic [2:0] f3);
    logic sgn;
    sgn = (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101);
    if (a == b) return 2'b00;
    if (sgn ? ($signed(a) < $signed(b)) : (a < b)) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic model_res(input logic [1:0] c, input logic [2:0] f3);
    case (f3)
      3'b000:         return c == 2'b00;
      3'b001:         return c != 2'b00;
      3'b101, 3'b111: return c != 2'b01;
      default:        return c == 2'b01;
    endcase
  endfunction

  function automatic int model_lanes(input logic [31:0] a, b, input logic ee);
    if (!ee) return 4;
    for (int i = 3; i >= 0; i--)
      if (a[i*8 +: 8] != b[i*8 +: 8]) return 4 - i;
    return 4;
  endfunction

  // Called at #1 after a rising edge with the selected DUT idle.
  task automatic run_op(input logic [31:0] a, b, input logic [2:0] f3, input int hold);
    exp_t       e;
    int         lat;
    logic [1:0] c0;
    logic       r0;
    chk("in_ready_idle", in_ready_s, 1);
    op1 = a; op2 = b; funct3 = f3;
    if (sel) in_valid_e1 = 1'b1; else in_valid_e0 = 1'b1;
    e.cmp = model_cmp(a, b, f3);
    e.res = model_res(e.cmp, f3);
    e.lat = model_lanes(a, b, sel) + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid_e1 = 1'b0; in_valid_e0 = 1'b0;
    lat = 1;
    op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom);
    while (!out_valid_s && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      op1 = $urandom; op2 = $urandom;
    end
    chk("out_valid_timeout", out_valid_s, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("cmp", cmp_s, e.cmp);
      chk("result", result_s, e.res);
      chk("latency", lat, e.lat);
    end
    chk("in_ready_busy", in_ready_s, 0);
    c0 = cmp_s; r0 = result_s;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom);
      chk("hold_valid", out_valid_s, 1);
      chk("hold_cmp", cmp_s, c0);
      chk("hold_result", result_s, r0);
      chk("hold_in_ready", in_ready_s, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid_s, 0);
    chk("in_ready_after", in_ready_s, 1);
  endtask

  initial begin
    logic [31:0] a, b;
    int          j;
    rst = 1'b1; in_valid_e1 = 1'b0; in_valid_e0 = 1'b0;
    op1 = '0; op2 = '0; funct3 = '0; out_ready = 1'b0; sel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state on both instances
    chk("rst_in_ready_e1", in_ready_e1, 1);
    chk("rst_out_valid_e1", out_valid_e1, 0);
    chk("rst_cmp_e1", cmp_e1, 0);
    chk("rst_result_e1", result_e1, 0);
    chk("rst_in_ready_e0", in_ready_e0, 1);
    chk("rst_out_valid_e0", out_valid_e0, 0);
    // No transfer while in reset
    in_valid_e1 = 1'b1;
    @(posedge clk); #1;
    in_valid_e1 = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_accept_ready", in_ready_e1, 1);
    chk("rst_no_accept_valid", out_valid_e1, 0);

    // Directed cases, early exit
    run_op(32'h8000_0000, 32'h0000_0001, 3'b100, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 3'b110, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 3'b000, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 3'b001, 0);
    run_op(32'h1234_5600, 32'h1234_56FF, 3'b010, 0);
    run_op(32'h1234_5600, 32'h1234_56FF, 3'b011, 0);
    // Back-pressure with operand churn
    run_op(32'hA500_0000, 32'h5A00_0000, 3'b111, 3);
    run_op(32'h0012_0000, 32'h0013_0000, 3'b101, 2);

    // Random operands that share leading bytes often
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = a;
      j = $urandom_range(0, 4);
      if (j < 4) b[j*8 +: 8] = 8'($urandom);
      run_op(a, b, 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    // Fixed-latency instance
    sel = 1'b0;
    run_op(32'hFF00_0000, 32'h0000_0000, 3'b100, 0);
    run_op(32'hFF00_0000, 32'h0000_0000, 3'b110, 1);
    run_op(32'h0000_0001, 32'h0000_0002, 3'b011, 0);

    // Reset while the early-exit instance is at lane 2
    sel = 1'b1;
    op1 = 32'h1200_0000; op2 = 32'h12FF_0000; funct3 = 3'b000;
    in_valid_e1 = 1'b1;
    @(posedge clk); #1;
    in_valid_e1 = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", in_ready_e1, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid_e1, 0);
    chk("mid_rst_ready", in_ready_e1, 1);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("discarded_no_valid", out_valid_e1, 0);
    end
    chk("post_rst_ready", in_ready_e1, 1);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b101, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
